stream_rr_arbiter: RTL and testbench

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

---
 rtl/stream_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_stream_rr_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// Round-robin AXI-Stream merger: grants one source per packet, forwarding beats
// through a single registered output stage tagged with the source index.
module stream_rr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 4,
  parameter int ID_WIDTH   = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   S_AXI_TDATA,
  input  logic [NUM_SRC*DATA_WIDTH/8-1:0] S_AXI_TKEEP,
  input  logic [NUM_SRC-1:0]              S_AXI_TVALID,
  output logic [NUM_SRC-1:0]              S_AXI_TREADY,
  input  logic [NUM_SRC-1:0]              S_AXI_TLAST,
  output logic [DATA_WIDTH-1:0]           M_AXI_TDATA,
  output logic [DATA_WIDTH/8-1:0]         M_AXI_TKEEP,
  output logic                            M_AXI_TLAST,
  output logic                            M_AXI_TVALID,
  input  logic                            M_AXI_TREADY,
  output logic [ID_WIDTH-1:0]             M_AXI_TID,
  output logic                            busy
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state, state_next;
  logic [ID_WIDTH-1:0]   grant, grant_next;
  logic [ID_WIDTH-1:0]   last_grant, last_grant_next;
  logic [ID_WIDTH-1:0]   rr_pick;
  logic                  rr_found;
  logic                  load_en;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic                  sel_valid;
  logic                  sel_last;

  assign load_en = !M_AXI_TVALID || M_AXI_TREADY;
  assign busy    = (state == BUSY);
  assign accept  = busy && sel_valid && load_en;

  // Search upward from the source after last_grant, wrapping at NUM_SRC.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    rr_pick  = '0;
    rr_found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (!rr_found && S_AXI_TVALID[j] && (j == (int'(last_grant) + i + 1) % NUM_SRC)) begin
          rr_found = 1'b1;
          rr_pick  = ID_WIDTH'(j);
        end
      end
    end
  end

  always_comb begin
    sel_data     = '0;
    sel_keep     = '0;
    sel_valid    = 1'b0;
    sel_last     = 1'b0;
    S_AXI_TREADY = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (grant == ID_WIDTH'(j)) begin
        sel_data        = S_AXI_TDATA[j*DATA_WIDTH +: DATA_WIDTH];
        sel_keep        = S_AXI_TKEEP[j*KEEP_WIDTH +: KEEP_WIDTH];
        sel_valid       = S_AXI_TVALID[j];
        sel_last        = S_AXI_TLAST[j];
        S_AXI_TREADY[j] = !reset && busy && load_en;
      end
    end
  end

  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        if (rr_found) begin
          grant_next = rr_pick;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // Grant is held for the whole packet, even across source stalls.
        if (accept && sel_last) begin
          last_grant_next = grant;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state        <= IDLE;
      grant        <= '0;
      last_grant   <= ID_WIDTH'(NUM_SRC - 1);
      M_AXI_TVALID <= 1'b0;
      M_AXI_TDATA  <= '0;
      M_AXI_TKEEP  <= '0;
      M_AXI_TLAST  <= 1'b0;
      M_AXI_TID    <= '0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
      if (load_en) begin
        M_AXI_TDATA  <= sel_data;
        M_AXI_TKEEP  <= sel_keep;
        M_AXI_TLAST  <= sel_last;
        M_AXI_TID    <= grant;
        M_AXI_TVALID <= busy && sel_valid;
      end
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a behavioural round-robin model.
module tb_stream_rr_arbiter;

  localparam int DW = 32;
  localparam int NS = 4;
  localparam int IW = 3;
  localparam int KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [NS*DW-1:0] s_tdata;
  logic [NS*KW-1:0] s_tkeep;
  logic [NS-1:0]    s_tvalid;
  logic [NS-1:0]    s_tready;
  logic [NS-1:0]    s_tlast;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             m_tlast;
  logic             m_tvalid;
  logic             m_tready;
  logic [IW-1:0]    m_tid;
  logic             busy;

  always #5 clk = ~clk;

  stream_rr_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .ID_WIDTH(IW)) dut (
    .clk(clk), .reset(reset),
    .S_AXI_TDATA(s_tdata), .S_AXI_TKEEP(s_tkeep), .S_AXI_TVALID(s_tvalid),
    .S_AXI_TREADY(s_tready), .S_AXI_TLAST(s_tlast),
    .M_AXI_TDATA(m_tdata), .M_AXI_TKEEP(m_tkeep), .M_AXI_TLAST(m_tlast),
    .M_AXI_TVALID(m_tvalid), .M_AXI_TREADY(m_tready), .M_AXI_TID(m_tid),
    .busy(busy)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t src_q [NS][$];
  int    order [$];
  bit    pkt_start;
  bit    gap_en;
  int    mready_pct;

  // Reference model: which source owns the output, who was served last, and the output slot.
  bit            mdl_busy;
  int            mdl_owner;
  int            mdl_last;
  bit            mdl_ov;
  logic [DW-1:0] mdl_od;
  logic [KW-1:0] mdl_ok;
  bit            mdl_ol;
  int            mdl_oid;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_next(input int last, input logic [NS-1:0] v);
    for (int k = 1; k <= NS; k++)
      if (v[(last + k) % NS]) return (last + k) % NS;
    return -1;
  endfunction

  task automatic push_beat(input int s, input logic [DW-1:0] d, input bit l);
    beat_t b;
    b.data = d;
    b.keep = KW'($urandom);
    b.last = l;
    src_q[s].push_back(b);
  endtask

  task automatic gen_pkt(input int s, input int len);
    logic [7:0] tag;
    tag = 8'($urandom);
    for (int b = 0; b < len; b++)
      push_beat(s, {8'(s), tag, 8'(b), 8'($urandom)}, b == len - 1);
  endtask

  task automatic model_reset();
    mdl_busy  = 0;
    mdl_owner = 0;
    mdl_last  = NS - 1;
    mdl_ov    = 0;
    mdl_od    = '0;
    mdl_ok    = '0;
    mdl_ol    = 0;
    mdl_oid   = 0;
    pkt_start = 1;
    order.delete();
  endtask

  task automatic step(input bit rst);
    logic [NS-1:0] rdy;
    bit            en;
    int            nx;
    @(negedge clk);
    reset    = rst;
    m_tready = ($urandom_range(0, 99) < mready_pct);
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
        s_tvalid[i]            = 1'b1;
        s_tdata[i*DW +: DW]    = src_q[i][0].data;
        s_tkeep[i*KW +: KW]    = src_q[i][0].keep;
        s_tlast[i]             = src_q[i][0].last;
      end else begin
        s_tvalid[i]            = 1'b0;
        s_tdata[i*DW +: DW]    = DW'($urandom);
        s_tkeep[i*KW +: KW]    = KW'($urandom);
        s_tlast[i]             = 1'($urandom);
      end
    end
    #1;
    check("s_tready", s_tready,
          (!rst && mdl_busy && (!mdl_ov || m_tready)) ? (64'd1 << mdl_owner) : 64'd0);
    check("busy", busy, mdl_busy);
    check("m_tvalid", m_tvalid, mdl_ov);
    check("m_tdata", m_tdata, mdl_od);
    check("m_tkeep", m_tkeep, mdl_ok);
    check("m_tlast", m_tlast, mdl_ol);
    check("m_tid", m_tid, mdl_oid);
    rdy = s_tready;
    if (m_tvalid && m_tready) begin
      if (pkt_start) order.push_back(int'(m_tid));
      pkt_start = m_tlast;
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      en = !mdl_ov || m_tready;
      if (en) begin
        mdl_od  = s_tdata[mdl_owner*DW +: DW];
        mdl_ok  = s_tkeep[mdl_owner*KW +: KW];
        mdl_ol  = s_tlast[mdl_owner];
        mdl_oid = mdl_owner;
        mdl_ov  = mdl_busy && s_tvalid[mdl_owner];
      end
      if (!mdl_busy) begin
        nx = rr_next(mdl_last, s_tvalid);
        if (nx >= 0) begin
          mdl_owner = nx;
          mdl_busy  = 1;
        end
      end else if (s_tvalid[mdl_owner] && en && s_tlast[mdl_owner]) begin
        mdl_last = mdl_owner;
        mdl_busy = 0;
      end
    end
    for (int i = 0; i < NS; i++)
      if (s_tvalid[i] && rdy[i]) void'(src_q[i].pop_front());
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NS; i++) src_q[i].delete();
  endtask

  initial begin
    int exp_order [4] = '{0, 2, 3, 0};
    reset      = 1'b1;
    s_tvalid   = '0;
    s_tdata    = '0;
    s_tkeep    = '0;
    s_tlast    = '0;
    m_tready   = 1'b0;
    gap_en     = 0;
    mready_pct = 100;
    repeat (3) @(negedge clk);
    model_reset();
    step(1);

    // Single source, three beats, continuous ready.
    push_beat(1, 32'hA1, 0);
    push_beat(1, 32'hA2, 0);
    push_beat(1, 32'hA3, 1);
    repeat (8) step(0);
    check("single_pkts", order.size(), 1);
    check("single_tid", (order.size() > 0) ? order[0] : -1, 1);

    // Round-robin order from reset: src0, src2, src3, then src0 again.
    step(1);
    gen_pkt(0, 2);
    gen_pkt(2, 2);
    gen_pkt(3, 2);
    gen_pkt(0, 2);
    repeat (16) step(0);
    check("rr_pkts", order.size(), 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("rr_order%0d", k), (k < order.size()) ? order[k] : -1, exp_order[k]);

    // Back-pressure mid-packet, then release.
    step(1);
    push_beat(2, 32'hB1, 0);
    push_beat(2, 32'hB2, 0);
    push_beat(2, 32'hB3, 1);
    repeat (3) step(0);
    mready_pct = 0;
    repeat (5) step(0);
    mready_pct = 100;
    repeat (5) step(0);

    // Reset in the middle of a src3 packet; src0 must win afterwards.
    step(1);
    clear_sources();
    gen_pkt(3, 4);
    repeat (3) step(0);
    step(1);
    gen_pkt(0, 2);
    repeat (10) step(0);
    check("post_reset_first", (order.size() > 0) ? order[0] : -1, 0);

    // Randomized traffic with stalls, back-pressure and occasional resets.
    clear_sources();
    gap_en     = 1;
    mready_pct = 70;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NS; i++)
        if (src_q[i].size() == 0 && $urandom_range(0, 3) == 0)
          gen_pkt(i, int'($urandom_range(1, 5)));
      step($urandom_range(0, 399) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
